dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the byte-addressed data memory (8 KiB, 1-cycle registered read, 2-bit access size). Port 0 is the CPU load/store stage and has priority. Port 1 is the DMA/debug port, protected by a starvation counter. The arbiter forwards one access per cycle, tracks the single in-flight read and routes its data back to the owning port.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_arbiter_if.sv | 25 ++
 rtl/dmem_arb_pick.sv | 25 ++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared size encodings and address helpers for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   localparam int unsigned MEM_BYTES_DEF = 32'd8192;
   localparam int unsigned CNT_W         = 32'd4;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      logic [3:0] n;
      case (size)
         SZ_B:    n = 4'd1;
         SZ_H:    n = 4'd2;
         SZ_W:    n = 4'd4;
         SZ_D:    n = 4'd8;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   function automatic logic addr_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic ok;
      case (size)
         SZ_B:    ok = 1'b1;
         SZ_H:    ok = (addr_lo[0] == 1'b0);
         SZ_W:    ok = (addr_lo[1:0] == 2'b00);
         SZ_D:    ok = (addr_lo == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle of one arbiter port; master = requester, slave = arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic              we;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output valid, we, size, addr, wdata,
      input  ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  valid, we, size, addr, wdata,
      output ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational grant: port 0 has priority unless port 1 has waited STARVE_LIMIT cycles.
module dmem_arb_pick
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             p0_valid_i,
   input  logic             p1_valid_i,
   input  logic [CNT_W-1:0] starve_cnt_i,
   output logic [1:0]       gnt_o
);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);

   // one-hot grant selection
   always_comb begin
      gnt_o = 2'b00;
      if (p1_valid_i && (!p0_valid_i || (starve_cnt_i == CNT_LIM))) begin
         gnt_o = 2'b10;
      end else if (p0_valid_i) begin
         gnt_o = 2'b01;
      end else begin
         gnt_o = 2'b00;
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with a single tracked in-flight read.
// Optional request checking (alignment/range, error response) under DMEM_ARB_CHECK_EN.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned MEM_BYTES    = MEM_BYTES_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     p0,
   dmem_arbiter_if.slave     p1,
   output logic              mem_read_o,
   output logic              mem_write_o,
   output logic [1:0]        mem_type_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);

   if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15) || (MEM_BYTES < 8)) begin : g_bad_cfg
      $error("dmem_arbiter: STARVE_LIMIT must be 1..15 and MEM_BYTES at least 8");
   end

   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              inflight_q, inflight_d;
   logic              owner_q, owner_d;
   logic [1:0]        err_q, err_d;
   logic [1:0]        gnt_s;
   logic              hs_s;
   logic              ok_s;
   logic              sel_we_s;
   logic [1:0]        sel_size_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;

   dmem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
      .p0_valid_i   (p0.valid),
      .p1_valid_i   (p1.valid),
      .starve_cnt_i (starve_cnt_q),
      .gnt_o        (gnt_s)
   );

   assign hs_s     = rst_n & (gnt_s[0] | gnt_s[1]);
   assign p0.ready = rst_n & gnt_s[0];
   assign p1.ready = rst_n & gnt_s[1];

   // winner request field mux
   always_comb begin
      sel_we_s    = 1'b0;
      sel_size_s  = 2'b00;
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      if (gnt_s[1]) begin
         sel_we_s    = p1.we;
         sel_size_s  = p1.size;
         sel_addr_s  = p1.addr;
         sel_wdata_s = p1.wdata;
      end else if (gnt_s[0]) begin
         sel_we_s    = p0.we;
         sel_size_s  = p0.size;
         sel_addr_s  = p0.addr;
         sel_wdata_s = p0.wdata;
      end else begin
         sel_we_s    = 1'b0;
      end
   end

`ifdef DMEM_ARB_CHECK_EN
   // range test written as addr <= MEM_BYTES - n so a huge address cannot wrap the sum
   assign ok_s = addr_aligned(sel_addr_s[2:0], sel_size_s) &
                 (sel_addr_s <= (ADDR_W'(MEM_BYTES) - ADDR_W'(size_bytes(sel_size_s))));
   assign p0.rsp_err = err_q[0];
   assign p1.rsp_err = err_q[1];
`else
   assign ok_s       = 1'b1;
   assign p0.rsp_err = 1'b0;
   assign p1.rsp_err = 1'b0;
`endif

   assign mem_read_o  = hs_s & ~sel_we_s & ok_s;
   assign mem_write_o = hs_s &  sel_we_s & ok_s;
   assign mem_type_o  = hs_s ? sel_size_s  : 2'b00;
   assign mem_addr_o  = hs_s ? sel_addr_s  : '0;
   assign mem_wdata_o = hs_s ? sel_wdata_s : '0;

   // next-state for read tracking, pending errors and port-1 starvation
   always_comb begin
      inflight_d   = hs_s & ~sel_we_s & ok_s;
      owner_d      = owner_q;
      err_d        = 2'b00;
      starve_cnt_d = starve_cnt_q;
      if (inflight_d) begin
         owner_d = gnt_s[1];
      end else begin
         owner_d = owner_q;
      end
      if (hs_s && !ok_s) begin
         err_d = gnt_s;
      end else begin
         err_d = 2'b00;
      end
      if (!p1.valid || gnt_s[1]) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q < CNT_LIM) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q   <= 1'b0;
         owner_q      <= 1'b0;
         err_q        <= 2'b00;
         starve_cnt_q <= '0;
      end else begin
         inflight_q   <= inflight_d;
         owner_q      <= owner_d;
         err_q        <= err_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign p0.rsp_valid = (inflight_q & ~owner_q) | err_q[0];
   assign p1.rsp_valid = (inflight_q &  owner_q) | err_q[1];
   assign p0.rsp_rdata = (inflight_q & ~owner_q) ? mem_rdata_i : '0;
   assign p1.rsp_rdata = (inflight_q &  owner_q) ? mem_rdata_i : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a byte-array memory and reference model.
module tb_dmem_arbiter;
   localparam int ADDR_W    = 64;
   localparam int DATA_W    = 64;
   localparam int MEM_BYTES = 8192;
   localparam int LIMIT     = 4;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_t;

   typedef struct packed {
      int          due;
      logic        err;
      logic [63:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p0_if ();
   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) p1_if ();

   logic        mem_read, mem_write;
   logic [1:0]  mem_type;
   logic [63:0] mem_addr, mem_wdata;
   logic [63:0] mem_rdata = 64'd0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n), .p0(p0_if), .p1(p1_if),
      .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_type_o(mem_type),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   logic [1:0] drv_valid = 2'b00;
   logic [1:0] taken     = 2'b00;
   req_t       drv_req [2];

   assign p0_if.valid = drv_valid[0];
   assign p0_if.we    = drv_req[0].we;
   assign p0_if.size  = drv_req[0].size;
   assign p0_if.addr  = drv_req[0].addr;
   assign p0_if.wdata = drv_req[0].wdata;
   assign p1_if.valid = drv_valid[1];
   assign p1_if.we    = drv_req[1].we;
   assign p1_if.size  = drv_req[1].size;
   assign p1_if.addr  = drv_req[1].addr;
   assign p1_if.wdata = drv_req[1].wdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int p1_wait = 0;
   int streak = 0;
   int streak_max = 0;
   logic rec = 1'b0;
   logic mem_init_done = 1'b0;
   int ghist[$];
   req_t rq0[$], rq1[$];
   exp_t sb0[$], sb1[$];

   logic [7:0] ram [MEM_BYTES];
   logic [7:0] ref_mem [MEM_BYTES];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37) + 11);
   endfunction

   function automatic logic [63:0] ram_read(input logic [63:0] a, input logic [1:0] sz);
      logic [63:0] d;
      d = 64'd0;
      for (int i = 0; i < (1 << sz); i++) d[8*i +: 8] = ram[13'(a[12:0] + 13'(i))];
      return d;
   endfunction

   function automatic logic [63:0] ref_read(input logic [63:0] a, input logic [1:0] sz);
      logic [63:0] d;
      d = 64'd0;
      for (int i = 0; i < (1 << sz); i++) d[8*i +: 8] = ref_mem[13'(a[12:0] + 13'(i))];
      return d;
   endfunction

   // behavioural memory: write at the edge, registered read data
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < MEM_BYTES; i++) ram[i] <= init_byte(i);
         mem_init_done <= 1'b1;
      end else begin
         if (mem_write)
            for (int i = 0; i < 8; i++)
               if (i < (1 << mem_type)) ram[13'(mem_addr[12:0] + 13'(i))] <= mem_wdata[8*i +: 8];
         if (mem_read) mem_rdata <= ram_read(mem_addr, mem_type);
      end
   end

   function automatic logic ref_ok(input logic [63:0] a, input logic [1:0] sz);
`ifdef DMEM_ARB_CHECK_EN
      return ((a % (64'd1 << sz)) == 64'd0) && ((a + (64'd1 << sz)) <= 64'(MEM_BYTES));
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic req_t mk(input logic we, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] wd);
      req_t r;
      r.we = we; r.size = sz; r.addr = a; r.wdata = wd;
      return r;
   endfunction

   function automatic req_t rand_req(input logic force_load);
      req_t r;
      r.we    = force_load ? 1'b0 : 1'($urandom_range(0, 1));
      r.size  = 2'($urandom_range(0, 3));
      r.addr  = 64'($urandom_range(0, 31)) << r.size;
      r.wdata = {$urandom, $urandom};
      return r;
   endfunction

   function automatic int qsize(input int p);
      return (p == 0) ? rq0.size() : rq1.size();
   endfunction

   function automatic req_t qhead(input int p);
      return (p == 0) ? rq0[0] : rq1[0];
   endfunction

   task automatic push_req(input int p, input req_t r);
      if (p == 0) rq0.push_back(r); else rq1.push_back(r);
   endtask

   task automatic flush_all();
      rq0.delete(); rq1.delete(); sb0.delete(); sb1.delete();
      drv_valid = 2'b00; taken = 2'b00; p1_wait = 0; streak = 0;
   endtask

   // one bus cycle: present requests, predict the grant, check the bus, queue expectations
   task automatic step(input int pct);
      int   win;
      req_t r;
      exp_t e;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (taken[p]) begin
            if (p == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            drv_valid[p] = 1'b0;
            taken[p] = 1'b0;
         end
         if (!drv_valid[p] && qsize(p) > 0 && $urandom_range(0, 99) < pct) begin
            drv_valid[p] = 1'b1;
            drv_req[p] = qhead(p);
         end
      end
      @(negedge clk);
      if (drv_valid[1] && (!drv_valid[0] || p1_wait >= LIMIT)) win = 1;
      else if (drv_valid[0]) win = 0;
      else win = -1;
      check("p0_ready", 64'(p0_if.ready), 64'(win == 0));
      check("p1_ready", 64'(p1_if.ready), 64'(win == 1));
      if (drv_valid[1] && !p1_if.ready) begin
         streak++;
         if (streak > streak_max) streak_max = streak;
      end else streak = 0;
      if (rec && (p0_if.ready || p1_if.ready)) ghist.push_back(p1_if.ready ? 1 : 0);
      if (win >= 0) begin
         r = drv_req[win];
         check("mem_read", 64'(mem_read), 64'(ref_ok(r.addr, r.size) && !r.we));
         check("mem_write", 64'(mem_write), 64'(ref_ok(r.addr, r.size) && r.we));
         e.due = cyc + 1;
         if (!ref_ok(r.addr, r.size)) begin
            e.err = 1'b1; e.data = 64'd0;
            if (win == 0) sb0.push_back(e); else sb1.push_back(e);
         end else begin
            check("mem_addr", mem_addr, r.addr);
            check("mem_type", 64'(mem_type), 64'(r.size));
            check("mem_wdata", mem_wdata, r.wdata);
            if (r.we) begin
               for (int i = 0; i < (1 << r.size); i++) ref_mem[13'(r.addr[12:0] + 13'(i))] = r.wdata[8*i +: 8];
            end else begin
               e.err = 1'b0; e.data = ref_read(r.addr, r.size);
               if (win == 0) sb0.push_back(e); else sb1.push_back(e);
            end
         end
         taken[win] = 1'b1;
      end else begin
         check("mem_idle", 64'({mem_read, mem_write}), 64'd0);
      end
      p1_wait = (drv_valid[1] && win != 1) ? p1_wait + 1 : 0;
   endtask

   task automatic mon_port(input int p, input logic v, input logic [63:0] d, input logic err);
      exp_t e;
      logic due_now;
      due_now = 1'b0;
      e = '0;
      if (p == 0 && sb0.size() > 0) e = sb0[0];
      if (p == 1 && sb1.size() > 0) e = sb1[0];
      if (((p == 0 && sb0.size() > 0) || (p == 1 && sb1.size() > 0)) && e.due <= cyc) begin
         due_now = 1'b1;
         if (p == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
      end
      check($sformatf("p%0d_rsp_valid", p), 64'(v), 64'(due_now));
      if (v && due_now) begin
         check($sformatf("p%0d_rsp_rdata", p), d, e.data);
         check($sformatf("p%0d_rsp_err", p), 64'(err), 64'(e.err));
      end else begin
         check($sformatf("p%0d_idle_rdata", p), d, 64'd0);
         check($sformatf("p%0d_idle_err", p), 64'(err), 64'd0);
      end
   endtask

   // response monitor, independent of the stimulus process
   always @(negedge clk) begin
      if (rst_n) begin
         mon_port(0, p0_if.rsp_valid, p0_if.rsp_rdata, p0_if.rsp_err);
         mon_port(1, p1_if.rsp_valid, p1_if.rsp_rdata, p1_if.rsp_err);
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((rq0.size() + rq1.size()) != 0 && n < 200) begin
         step(100);
         n++;
      end
      repeat (2) step(100);
      check("drain_timeout", 64'(rq0.size() + rq1.size()), 64'd0);
   endtask

   task automatic check_pattern(input int n);
      check("grant_hist_len", 64'(ghist.size() >= n), 64'd1);
      for (int i = 0; i < n && i < ghist.size(); i++)
         check($sformatf("grant_pattern[%0d]", i), 64'(ghist[i]), 64'((i % (LIMIT + 1)) == LIMIT));
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
      drv_req[0] = mk(1'b0, 2'd3, 64'h40, 64'd0);
      drv_req[1] = mk(1'b1, 2'd3, 64'h48, 64'hffff);
      drv_valid = 2'b11;
      #12;
      check("rst_p0_ready", 64'(p0_if.ready), 64'd0);
      check("rst_p1_ready", 64'(p1_if.ready), 64'd0);
      check("rst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_rsp_valid", 64'({p1_if.rsp_valid, p0_if.rsp_valid}), 64'd0);
      drv_valid = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      push_req(0, mk(1'b1, 2'd3, 64'h40, 64'h1122334455667788));
      push_req(0, mk(1'b0, 2'd3, 64'h40, 64'd0));
      repeat (4) step(100);
      check("plan_ref_double", ref_read(64'h40, 2'd3), 64'h1122334455667788);

      rec = 1'b1;
      ghist.delete();
      for (int i = 0; i < 12; i++) begin
         push_req(0, rand_req(1'b0));
         push_req(1, rand_req(1'b0));
      end
      repeat (12) step(100);
      rec = 1'b0;
      check_pattern(10);
      drain();

      for (int i = 0; i < 6; i++) begin
         push_req((i % 2 == 0) ? 1 : 0, rand_req(1'b1));
         step(100);
      end
      drain();

      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++)
            if (qsize(p) < 3 && $urandom_range(0, 99) < 50) push_req(p, rand_req(1'b0));
         step(70);
      end
      drain();

`ifdef DMEM_ARB_CHECK_EN
      push_req(1, mk(1'b0, 2'd2, 64'h2, 64'd0));
      step(100);
      push_req(0, mk(1'b1, 2'd3, 64'd8190, 64'hdeadbeefcafef00d));
      step(100);
      push_req(1, mk(1'b0, 2'd0, 64'd8191, 64'd0));
      step(100);
      drain();
`endif

      push_req(0, mk(1'b0, 2'd3, 64'h40, 64'd0));
      step(100);
      @(posedge clk);
      #1;
      drv_valid[0] = 1'b1;
      drv_req[0] = mk(1'b0, 2'd2, 64'h80, 64'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_p0_rsp_valid", 64'(p0_if.rsp_valid), 64'd0);
      check("midrst_p0_rdata", p0_if.rsp_rdata, 64'd0);
      check("midrst_p0_ready", 64'(p0_if.ready), 64'd0);
      check("midrst_mem_rw", 64'({mem_read, mem_write}), 64'd0);
      check("midrst_mem_addr", mem_addr, 64'd0);
      flush_all();
      @(negedge clk);
      rst_n = 1'b1;
      rec = 1'b1;
      ghist.delete();
      for (int i = 0; i < 6; i++) begin
         push_req(0, rand_req(1'b0));
         push_req(1, rand_req(1'b0));
      end
      repeat (6) step(100);
      rec = 1'b0;
      check_pattern(5);
      drain();

      check("sb_empty", 64'(sb0.size() + sb1.size()), 64'd0);
      check("p1_max_wait", 64'(streak_max > LIMIT), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
